mem_arbiter: RTL and testbench

Round-robin arbiter sharing the single-port `memory` block (12-bit word address, 16-bit tagged words) among several requesters: the evaluator core, and later the garbage collector and debug port. It holds one outstanding memory transaction at a time and drives the memory's single-cycle `req` pulse protocol. It returns read data or write acknowledgement to the owning requester, and aborts stalled transactions with an error response after a bounded wait.

---
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle of the memory arbiter: requester-side handshake plus the memory `req` pulse port.
// `slave` is the arbiter's view and `master` is the view of the requesters and the memory.
interface mem_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 16
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_accept;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_error;
    logic                      busy;
    logic                      mem_req;
    logic [ADDR_W-1:0]         mem_addr;
    logic                      mem_we;
    logic [DATA_W-1:0]         mem_wdata;
    logic                      mem_ready;
    logic [DATA_W-1:0]         mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_ready, mem_rdata,
        output req_accept, rsp_valid, rsp_data, rsp_error, busy,
        output mem_req, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_ready, mem_rdata,
        input  req_accept, rsp_valid, rsp_data, rsp_error, busy,
        input  mem_req, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving several requesters one-at-a-time access to the single-port memory,
// with a bounded wait that turns a stalled transaction into an error response.
module mem_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);
    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StRespond} state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [PtrW-1:0]   owner_q, owner_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              found;
    logic [PtrW-1:0]   winner;
    logic [ADDR_W-1:0] win_addr;
    logic              win_we;
    logic [DATA_W-1:0] win_wdata;
    int unsigned       idx;

    // First valid requester at or above ptr, wrapping around.
    always_comb begin
        found     = 1'b0;
        winner    = '0;
        win_addr  = '0;
        win_we    = 1'b0;
        win_wdata = '0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(ptr_q) + i) % NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found     = 1'b1;
                winner    = PtrW'(idx);
                win_addr  = bus.req_addr[idx*ADDR_W +: ADDR_W];
                win_we    = bus.req_we[idx];
                win_wdata = bus.req_wdata[idx*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    owner_d = winner;
                    addr_d  = win_addr;
                    we_d    = win_we;
                    wdata_d = win_wdata;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // A ready on the expiry edge still completes the transaction normally.
                if (bus.mem_ready) begin
                    rdata_d = we_q ? '0 : bus.mem_rdata;
                    err_d   = 1'b0;
                    state_d = StRespond;
                end else if (cnt_q + 8'd1 == 8'(TIMEOUT)) begin
                    cnt_d   = cnt_q + 8'd1;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StRespond;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StRespond: begin
                ptr_d   = PtrW'((32'(owner_q) + 1) % NUM_REQ);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        bus.req_accept = '0;
        bus.rsp_valid  = '0;
        if (state_q == StIssue) bus.req_accept[owner_q] = 1'b1;
        if (state_q == StRespond) bus.rsp_valid[owner_q] = 1'b1;
    end

    assign bus.rsp_data  = rdata_q;
    assign bus.rsp_error = err_q & (state_q == StRespond);
    assign bus.busy      = (state_q != StIdle);
    assign bus.mem_req   = (state_q == StIssue);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions push expected grants, memory
// requests and responses; a monitor on the falling edge pops and compares them.
module tb_mem_arbiter;
    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned TIMEOUT = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mem_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [15:0] data;
        logic        err;
        int          lat;
    } rsp_t;

    typedef struct {
        logic [11:0] addr;
        logic        we;
        logic [15:0] wdata;
    } mem_t;

    rsp_t        exp_rsp[$];
    mem_t        exp_mem[$];
    int          exp_grant[$];
    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    int          acc_cyc[NUM_REQ];
    int          mem_lat = 1;   // 0: memory never answers
    logic [15:0] rbase = '0;
    int          cd = 0;
    logic [11:0] last_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic expect_txn(input int idx, input logic [11:0] addr, input logic we,
                              input logic [15:0] wdata, input logic [15:0] rdata,
                              input logic err, input int lat);
        rsp_t r;
        mem_t m;
        r.idx = idx; r.data = rdata; r.err = err; r.lat = lat;
        m.addr = addr; m.we = we; m.wdata = wdata;
        exp_grant.push_back(idx);
        exp_mem.push_back(m);
        exp_rsp.push_back(r);
    endtask

    // Memory model: ready mem_lat cycles after the ISSUE cycle, data = rbase ^ address.
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            bus.mem_rdata = '0;
            if (bus.mem_req) begin
                cd        = mem_lat;
                last_addr = bus.mem_addr;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = rbase ^ {4'h0, last_addr};
                end
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        int   g;
        rsp_t e;
        mem_t m;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (bus.req_accept != '0) begin
                    check("accept_onehot", 32'($onehot(bus.req_accept)), 1);
                    check("accept_rsp_excl", 32'(bus.rsp_valid), 0);
                    check("busy_at_accept", 32'(bus.busy), 1);
                    if (exp_grant.size() == 0) begin
                        check("unexpected_accept", 32'(bus.req_accept), 0);
                    end else begin
                        g = exp_grant.pop_front();
                        check("grant", 32'(bus.req_accept), 32'(1) << g);
                    end
                    for (int i = 0; i < NUM_REQ; i++) if (bus.req_accept[i]) acc_cyc[i] = cyc;
                end
                if (bus.mem_req) begin
                    if (exp_mem.size() == 0) begin
                        check("unexpected_mem_req", 32'(bus.mem_req), 0);
                    end else begin
                        m = exp_mem.pop_front();
                        check("mem_addr", 32'(bus.mem_addr), 32'(m.addr));
                        check("mem_we", 32'(bus.mem_we), 32'(m.we));
                        if (m.we) check("mem_wdata", 32'(bus.mem_wdata), 32'(m.wdata));
                    end
                end
                if (bus.rsp_valid != '0) begin
                    check("rsp_onehot", 32'($onehot(bus.rsp_valid)), 1);
                    if (exp_rsp.size() == 0) begin
                        check("unexpected_rsp", 32'(bus.rsp_valid), 0);
                    end else begin
                        e = exp_rsp.pop_front();
                        check("rsp_owner", 32'(bus.rsp_valid), 32'(1) << e.idx);
                        check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                        check("rsp_error", 32'(bus.rsp_error), 32'(e.err));
                        check("rsp_latency", 32'(cyc - acc_cyc[e.idx]), 32'(e.lat));
                    end
                end
            end
        end
    end

    task automatic drive_req(input int i, input logic we, input logic [11:0] addr,
                             input logic [15:0] wdata);
        int n;
        n = 0;
        bus.req_valid[i] = 1'b1;
        bus.req_we[i] = we;
        bus.req_addr[i*ADDR_W +: ADDR_W] = addr;
        bus.req_wdata[i*DATA_W +: DATA_W] = wdata;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_accept[i] && n < 200);
        if (n >= 200) check("accept_timeout", 32'(bus.req_accept[i]), 1);
        @(posedge clk);
        #1;
        bus.req_valid[i] = 1'b0;
    endtask

    // Both requesters held valid until `count` accepts have been seen.
    task automatic run_both(input int count, input logic [11:0] a0, input logic [11:0] a1);
        int n;
        int seen;
        n = 0;
        seen = 0;
        bus.req_we = '0;
        bus.req_wdata = '0;
        bus.req_addr[0 +: ADDR_W] = a0;
        bus.req_addr[ADDR_W +: ADDR_W] = a1;
        bus.req_valid = 2'b11;
        while (seen < count && n < 400) begin
            @(negedge clk);
            n++;
            if (bus.req_accept != '0) seen++;
        end
        if (n >= 400) check("both_accept_timeout", 32'(seen), 32'(count));
        @(posedge clk);
        #1;
        bus.req_valid = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_rsp.size() != 0 || bus.busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_rsp.size()), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_accept"}, 32'(bus.req_accept), 0);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
        check({tag, "_rsp_data"}, 32'(bus.rsp_data), 0);
        check({tag, "_rsp_error"}, 32'(bus.rsp_error), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_mem_req"}, 32'(bus.mem_req), 0);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
        check({tag, "_mem_we"}, 32'(bus.mem_we), 0);
        check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 0);
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        #1;
        check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single read, memory answers one cycle after the request.
        mem_lat = 1; rbase = 16'h1001;
        expect_txn(0, 12'h004, 1'b0, 16'h0000, 16'h1005, 1'b0, 2);
        drive_req(0, 1'b0, 12'h004, 16'h0000);
        drain();

        // Write returns zero data even though the memory drives data.
        expect_txn(1, 12'h010, 1'b1, 16'hBEEF, 16'h0000, 1'b0, 2);
        drive_req(1, 1'b1, 12'h010, 16'hBEEF);
        drain();

        // Contention: strict alternation starting at requester 0.
        mem_lat = 2; rbase = 16'h5000;
        expect_txn(0, 12'h100, 1'b0, 16'h0000, 16'h5100, 1'b0, 3);
        expect_txn(1, 12'h200, 1'b0, 16'h0000, 16'h5200, 1'b0, 3);
        expect_txn(0, 12'h100, 1'b0, 16'h0000, 16'h5100, 1'b0, 3);
        expect_txn(1, 12'h200, 1'b0, 16'h0000, 16'h5200, 1'b0, 3);
        run_both(4, 12'h100, 12'h200);
        drain();

        // Timeout after 15 WAIT cycles; the late ready at cycle 20 must be ignored.
        mem_lat = 20; rbase = 16'h7777;
        expect_txn(0, 12'h020, 1'b0, 16'h0000, 16'h0000, 1'b1, 16);
        drive_req(0, 1'b0, 12'h020, 16'h0000);
        drain();
        repeat (30) @(negedge clk);
        check("rsp_data_hold_after_late_ready", 32'(bus.rsp_data), 0);
        check("idle_after_late_ready", 32'(bus.busy), 0);

        mem_lat = 1; rbase = 16'h1001;
        expect_txn(1, 12'h030, 1'b0, 16'h0000, 16'h1031, 1'b0, 2);
        drive_req(1, 1'b0, 12'h030, 16'h0000);
        drain();

        // Ready on the same edge the counter expires: data wins over error.
        mem_lat = 15; rbase = 16'h2ABC;
        expect_txn(0, 12'h000, 1'b0, 16'h0000, 16'h2ABC, 1'b0, 16);
        drive_req(0, 1'b0, 12'h000, 16'h0000);
        drain();

        // Reset mid-WAIT with requester 1 in flight (ptr was 1 before reset).
        mem_lat = 0;
        exp_grant.push_back(1);
        begin
            mem_t m;
            m.addr = 12'h040; m.we = 1'b0; m.wdata = 16'h0000;
            exp_mem.push_back(m);
        end
        drive_req(1, 1'b0, 12'h040, 16'h0000);
        repeat (3) @(negedge clk);
        check("busy_before_reset", 32'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // After reset ptr is 0, so requester 0 wins first.
        mem_lat = 1; rbase = 16'h1001;
        expect_txn(0, 12'h050, 1'b0, 16'h0000, 16'h1051, 1'b0, 2);
        expect_txn(1, 12'h060, 1'b0, 16'h0000, 16'h1061, 1'b0, 2);
        run_both(2, 12'h050, 12'h060);
        drain();

        repeat (5) @(negedge clk);
        check("grant_queue_empty", 32'(exp_grant.size()), 0);
        check("mem_queue_empty", 32'(exp_mem.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", passes, checks);
        $fatal(1);
    end
endmodule
